// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b, one bit per clock, LSB first.
// Ports: clk, rst_n (async, active-low); start/a/b in (sampled when ready);
//   ready (idle), done (1-cycle pulse), diff and borrow_out (held until next done).
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t st;
  state_t st_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             bor;
  logic             d;
  logic             bn;
  logic             last;

  assign d    = sa[0] ^ sb[0] ^ bor;
  assign bn   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
  assign last = (cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB; after WIDTH shifts the LSB-first
  // stream sits in natural order.
  assign res_nx = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));

  assign ready = (st == IDLE);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = RUN;
      RUN:     if (last) st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            bor <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          res <= res_nx;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bor <= bn;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff       <= res_nx;
            borrow_out <= bn;
            done       <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Randomized/directed bench for serial_ripple_subtractor at WIDTH 4, 1 and 8.
// Expected results come from plain (a - b) arithmetic in the bench.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       ready4, done4, bo4;
  logic [3:0] diff4;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       ready1, done1, bo1;
  logic [0:0] diff1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ready8, done8, bo8;
  logic [7:0] diff8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  serial_ripple_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  serial_ripple_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic s,
                        input logic [7:0] a, input logic [7:0] b);
    case (w)
      1: begin start1 = s; a1 = a[0]; b1 = b[0]; end
      4: begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; end
      default: begin start8 = s; a8 = a; b8 = b; end
    endcase
  endtask

  function automatic logic get_ready(input int w);
    case (w)
      1: return ready1;
      4: return ready4;
      default: return ready8;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1: return done1;
      4: return done4;
      default: return done8;
    endcase
  endfunction

  function automatic logic [7:0] get_diff(input int w);
    case (w)
      1: return {7'd0, diff1};
      4: return {4'd0, diff4};
      default: return diff8;
    endcase
  endfunction

  function automatic logic get_bo(input int w);
    case (w)
      1: return bo1;
      4: return bo4;
      default: return bo8;
    endcase
  endfunction

  // One operation on the instance of width w. While busy, random start
  // pulses and operand noise are driven; they must have no effect.
  task automatic op(input int w, input int a, input int b);
    int m;
    int ed;
    int eb;
    int dones;
    int at;
    logic [7:0] pd;
    logic pb;
    m  = (1 << w) - 1;
    a  = a & m;
    b  = b & m;
    ed = (a - b) & m;
    eb = (a < b) ? 1 : 0;
    @(negedge clk);
    check("ready_idle", get_ready(w), 1);
    pd = get_diff(w);
    pb = get_bo(w);
    set_in(w, 1'b1, 8'(a), 8'(b));
    dones = 0;
    at = -1;
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      if (get_done(w)) begin
        dones++;
        at = k - 1;
      end
      if (k <= w) begin
        check("ready_busy", get_ready(w), 0);
        set_in(w, 1'($urandom), 8'($urandom), 8'($urandom));
      end
      if (k == 1) begin
        check("diff_hold", get_diff(w), pd);
        check("bo_hold", get_bo(w), pb);
      end
    end
    @(negedge clk);
    if (get_done(w)) dones++;
    set_in(w, 1'b0, 8'd0, 8'd0);
    check("done_count", dones, 1);
    check("done_edge", at, w);
    check("ready_back", get_ready(w), 1);
    check("diff", get_diff(w), ed);
    check("borrow", get_bo(w), eb);
  endtask

  initial begin
    int qa[$];
    int qb[$];
    int last_acc;
    int n_acc;
    int ea;
    int eb;
    bit seen;

    @(negedge clk);
    check("rst_ready4", ready4, 1);
    check("rst_done4", done4, 0);
    check("rst_diff4", diff4, 0);
    check("rst_bo4", bo4, 0);
    check("rst_ready1", ready1, 1);
    check("rst_diff8", diff8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(4, 3, 2);
    op(4, 2, 3);
    op(4, 0, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op(4, i, j);

    op(1, 0, 1);
    op(1, 1, 0);
    op(1, 1, 1);
    op(8, 0, 255);
    op(8, 255, 0);
    for (int i = 0; i < 20; i++) begin
      op(8, int'($urandom_range(255)), int'($urandom_range(255)));
      op(1, int'($urandom_range(1)), int'($urandom_range(1)));
    end

    // Back-to-back: start held high, operands change every cycle.
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      start4 = (c < 30);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      if (start4 && ready4) begin
        qa.push_back(int'(a4));
        qb.push_back(int'(b4));
        if (last_acc >= 0) check("acc_gap", c - last_acc, 6);
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
      if (done4) begin
        if (qa.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          check("b2b_diff", diff4, (ea - eb) & 15);
          check("b2b_borrow", bo4, (ea < eb) ? 1 : 0);
        end
      end
    end
    check("b2b_accepts", n_acc, 5);
    check("b2b_drained", qa.size(), 0);

    // Reset in the middle of an operation.
    op(4, 7, 2);
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'd9;
    b4 = 4'd4;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready4, 1);
    check("mid_rst_diff", diff4, 0);
    check("mid_rst_bo", bo4, 0);
    check("mid_rst_done", done4, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (done4) seen = 1'b1;
    end
    check("mid_rst_nodone", seen, 0);
    check("mid_rst_diff2", diff4, 0);
    op(4, 9, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
